// File: rtl/modexp_pkg.sv
// -----------------------------------------------------------------------------
// modexp_pkg
// Shared definitions for the modular-exponentiation sequencer:
//   - default operand widths (DATA_WIDTH_DEF, E_WIDTH_DEF)
//   - FSM state encoding (state_t)
// S_SCAN is only reachable when MODEXP_SKIP_LZ_EN is defined.
// -----------------------------------------------------------------------------
package modexp_pkg;

  localparam int DATA_WIDTH_DEF = 1024;
  localparam int E_WIDTH_DEF    = 1024;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_TOMONT   = 3'd2,
    S_SQ       = 3'd3,
    S_MUL      = 3'd4,
    S_FROMMONT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
// Modular-exponentiation sequencer: result = in_x^in_e mod in_m using
// left-to-right square-and-multiply in the Montgomery domain. Drives one
// external Montgomery core through a start/done handshake.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start              one-cycle request, honoured only in S_IDLE
//   in_x, in_e, in_m   base (< m), exponent, odd modulus
//   in_rmodm           R mod m   (Montgomery representation of 1)
//   in_r2modm          R^2 mod m (conversion constant into Montgomery domain)
//   result             x^e mod m, held until overwritten by the next operation
//   done               one-cycle pulse, result valid in the same cycle
//   mont_start         one-cycle pulse launching a Montgomery multiply
//   mont_a, mont_b     multiply operands, stable from mont_start to mont_done
//   mont_m             modulus copy, stable for the whole operation
//   mont_result        a*b*R^-1 mod m, valid while mont_done = 1
//   mont_done          one-cycle completion pulse from the core
//
// Build option
//   MODEXP_SKIP_LZ_EN  skip leading zero exponent bits (S_SCAN) and the
//                      first square at the top set bit. Results are the same
//                      in both builds; only the multiply count differs.
// -----------------------------------------------------------------------------
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int E_WIDTH    = E_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [E_WIDTH-1:0]    in_e,
  input  logic [DATA_WIDTH-1:0] in_m,
  input  logic [DATA_WIDTH-1:0] in_rmodm,
  input  logic [DATA_WIDTH-1:0] in_r2modm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  mont_start,
  output logic [DATA_WIDTH-1:0] mont_a,
  output logic [DATA_WIDTH-1:0] mont_b,
  output logic [DATA_WIDTH-1:0] mont_m,
  input  logic [DATA_WIDTH-1:0] mont_result,
  input  logic                  mont_done
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] I_TOP = IW'(E_WIDTH - 1);

  state_t                state;
  logic [E_WIDTH-1:0]    e_q;
  logic [IW-1:0]         i_q;     // exponent bit currently being processed
  logic [DATA_WIDTH-1:0] acc;     // running accumulator, Montgomery domain
  logic [DATA_WIDTH-1:0] xm;      // x in Montgomery domain
`ifdef MODEXP_SKIP_LZ_EN
  logic [DATA_WIDTH-1:0] x_q;     // held until S_TOMONT, after the scan
  logic [DATA_WIDTH-1:0] r2_q;
`endif

  // The core's answer is only taken once the launch cycle has passed, so a
  // stray mont_done coinciding with mont_start is never mistaken for a result.
  logic take;
  assign take = mont_done && !mont_start;

  // Every transition into a multiply state loads mont_a/mont_b and raises
  // mont_start in the same edge; the operand registers then hold until the
  // next launch, which keeps them stable while the core is busy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      result     <= '0;
      done       <= 1'b0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      e_q        <= '0;
      i_q        <= '0;
      acc        <= '0;
      xm         <= '0;
`ifdef MODEXP_SKIP_LZ_EN
      x_q        <= '0;
      r2_q       <= '0;
`endif
    end else begin
      done       <= 1'b0;
      mont_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            e_q    <= in_e;
            mont_m <= in_m;
            acc    <= in_rmodm;
            i_q    <= I_TOP;
`ifdef MODEXP_SKIP_LZ_EN
            x_q    <= in_x;
            r2_q   <= in_r2modm;
            state  <= S_SCAN;
`else
            state      <= S_TOMONT;
            mont_start <= 1'b1;
            mont_a     <= in_x;
            mont_b     <= in_r2modm;
`endif
          end
        end

`ifdef MODEXP_SKIP_LZ_EN
        // Walk down to the most significant set bit. If none is found the
        // exponent is zero and the answer is simply acc = R mod m converted
        // out of the Montgomery domain.
        S_SCAN: begin
          if (!e_q[i_q] && (i_q != '0)) begin
            i_q <= i_q - 1'b1;
          end else if (!e_q[i_q]) begin
            state      <= S_FROMMONT;
            mont_start <= 1'b1;
            mont_a     <= acc;
            mont_b     <= ONE;
          end else begin
            state      <= S_TOMONT;
            mont_start <= 1'b1;
            mont_a     <= x_q;
            mont_b     <= r2_q;
          end
        end
`endif

        S_TOMONT: begin
          if (take) begin
            xm <= mont_result;
`ifdef MODEXP_SKIP_LZ_EN
            // Top set bit: squaring 1 then multiplying by x gives x, so the
            // accumulator is loaded with xm directly.
            acc <= mont_result;
            if (i_q != '0) begin
              i_q        <= i_q - 1'b1;
              state      <= S_SQ;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= mont_result;
            end else begin
              state      <= S_FROMMONT;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= ONE;
            end
`else
            state      <= S_SQ;
            mont_start <= 1'b1;
            mont_a     <= acc;
            mont_b     <= acc;
`endif
          end
        end

        S_SQ: begin
          if (take) begin
            acc <= mont_result;
            if (e_q[i_q]) begin
              state      <= S_MUL;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= xm;
            end else if (i_q != '0) begin
              i_q        <= i_q - 1'b1;
              state      <= S_SQ;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= mont_result;
            end else begin
              state      <= S_FROMMONT;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= ONE;
            end
          end
        end

        S_MUL: begin
          if (take) begin
            acc <= mont_result;
            if (i_q != '0) begin
              i_q        <= i_q - 1'b1;
              state      <= S_SQ;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= mont_result;
            end else begin
              state      <= S_FROMMONT;
              mont_start <= 1'b1;
              mont_a     <= mont_result;
              mont_b     <= ONE;
            end
          end
        end

        // Multiplying by plain 1 removes the R factor: acc*1*R^-1 = x^e mod m.
        S_FROMMONT: begin
          if (take) begin
            result <= mont_result;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modexp_ctrl
// Self-checking bench for modexp_ctrl at DATA_WIDTH=16, E_WIDTH=8, with a
// behavioural Montgomery core (programmable latency 1..40) and a plain
// arithmetic reference for x^e mod m and for the expected multiply count.
// -----------------------------------------------------------------------------
module tb_modexp_ctrl;

  localparam int DW = 16;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [DW-1:0] in_x, in_m, in_rmodm, in_r2modm;
  logic [EW-1:0] in_e;
  logic [DW-1:0] result;
  logic          done;
  logic          mont_start;
  logic [DW-1:0] mont_a, mont_b, mont_m;
  logic [DW-1:0] mont_result;
  logic          mont_done;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATA_WIDTH(DW), .E_WIDTH(EW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_x        (in_x),
    .in_e        (in_e),
    .in_m        (in_m),
    .in_rmodm    (in_rmodm),
    .in_r2modm   (in_r2modm),
    .result      (result),
    .done        (done),
    .mont_start  (mont_start),
    .mont_a      (mont_a),
    .mont_b      (mont_b),
    .mont_m      (mont_m),
    .mont_result (mont_result),
    .mont_done   (mont_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference arithmetic ----------------
  // a*b*2^-16 mod m by bitwise halving (m odd).
  function automatic longint mont_ref(longint a, longint b, longint m);
    longint t;
    t = a * b;
    for (int k = 0; k < DW; k++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    if (t >= m) t = t - m;
    return t;
  endfunction

  function automatic longint pow_ref(longint x, int e, longint m);
    longint r;
    r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int pulses_ref(int e);
    int pc, top;
    pc = 0; top = -1;
    for (int k = 0; k < EW; k++) if (e[k]) begin pc++; top = k; end
`ifdef MODEXP_SKIP_LZ_EN
    if (e == 0) return 1;
    return 2 + top + (pc - 1);
`else
    return 2 + EW + pc;
`endif
  endfunction

  // ---------------- behavioural Montgomery core + monitors ----------------
  int      core_lat = 3;
  bit      lat_rand = 1'b0;
  bit      busy = 1'b0;
  int      cnt = 0;
  logic [DW-1:0] la, lb, lm;
  logic    prev_ms = 1'b0;
  int      start_pulses = 0;
  int      done_pulses = 0;
  int      stab_err = 0;
  int      wide_err = 0;

  initial begin
    mont_done   = 1'b0;
    mont_result = '0;
  end

  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      busy      = 1'b0;
      mont_done = 1'b0;
      prev_ms   = 1'b0;
    end else begin
      if (mont_done) mont_done = 1'b0;
      if (mont_start) begin
        start_pulses++;
        if (prev_ms) wide_err++;
      end
      prev_ms = mont_start;
      if (done) done_pulses++;
      if (busy) begin
        if (mont_a !== la || mont_b !== lb || mont_m !== lm) stab_err++;
        cnt--;
        if (cnt <= 0) begin
          mont_result = DW'(mont_ref(longint'(la), longint'(lb), longint'(lm)));
          mont_done   = 1'b1;
          busy        = 1'b0;
        end
      end else if (mont_start) begin
        busy = 1'b1;
        la = mont_a; lb = mont_b; lm = mont_m;
        cnt = lat_rand ? int'($urandom_range(1, 40)) : core_lat;
      end
    end
  end

  // ---------------- operation driver ----------------
  task automatic drive_inputs(input logic [DW-1:0] x, input logic [EW-1:0] e,
                              input logic [DW-1:0] m);
    longint r;
    r = 65536 % longint'(m);
    in_x      = x;
    in_e      = e;
    in_m      = m;
    in_rmodm  = DW'(r);
    in_r2modm = DW'((r * r) % longint'(m));
  endtask

  // Runs one operation; optionally pulses start again at cycle restart_at.
  task automatic run_op(input logic [DW-1:0] x, input logic [EW-1:0] e,
                        input logic [DW-1:0] m, input int restart_at,
                        output logic [DW-1:0] res, output int pulses,
                        output bit ok, output logic done_after);
    int s0;
    @(negedge clk);
    drive_inputs(x, e, m);
    start = 1'b1;
    s0 = start_pulses;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    res = '0;
    for (int c = 0; c < 5000; c++) begin
      if (done === 1'b1) begin
        ok  = 1'b1;
        res = result;
        break;
      end
      if (c == restart_at) begin
        drive_inputs(x ^ 16'h0011, ~e, m);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    done_after = done;
    pulses = start_pulses - s0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetn = 1'b0;
    start  = 1'b0;
    drive_inputs(16'd0, 8'd0, 16'd7);
    repeat (3) @(negedge clk);
    n_checks++; if (result !== 16'd0) $display("FAIL reset_result: got %0h want 0", result); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mont_start !== 1'b0) $display("FAIL reset_mont_start: got %b want 0", mont_start); else n_pass++;
    n_checks++; if ({mont_a, mont_b, mont_m} !== 48'd0)
      $display("FAIL reset_operands: got a=%0h b=%0h m=%0h want 0", mont_a, mont_b, mont_m); else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [DW-1:0] x,
                          input logic [EW-1:0] e, input logic [DW-1:0] m,
                          input int restart_at);
    logic [DW-1:0] res, exp_res;
    int pulses, exp_p;
    bit ok;
    logic done_after;
    exp_res = DW'(pow_ref(longint'(x), int'(e), longint'(m)));
    exp_p   = pulses_ref(int'(e));
    run_op(x, e, m, restart_at, res, pulses, ok, done_after);
    n_checks++;
    if (!ok) $display("FAIL %s_timeout: no done within bound", name);
    else if (res !== exp_res) $display("FAIL %s_result: got %0h want %0h", name, res, exp_res);
    else n_pass++;
    n_checks++; if (pulses != exp_p) $display("FAIL %s_pulses: got %0d want %0d", name, pulses, exp_p); else n_pass++;
    n_checks++; if (done_after !== 1'b0) $display("FAIL %s_done_width: done still %b a cycle later", name, done_after); else n_pass++;
  endtask

  task automatic test_directed;
    core_lat = 2; lat_rand = 1'b0;
    check_op("e5", 16'd3, 8'h05, 16'd7, -1);
    core_lat = 1;
    check_op("e0", 16'h0042, 8'h00, 16'h00C5, -1);
    core_lat = 7;
    check_op("eff", 16'd2, 8'hFF, 16'h00C5, -1);
    core_lat = 4;
    check_op("e1", 16'h00B0, 8'h01, 16'h00C5, -1);
  endtask

  task automatic test_start_ignored;
    int d0;
    core_lat = 5; lat_rand = 1'b0;
    d0 = done_pulses;
    check_op("restart", 16'h0037, 8'hA6, 16'h00C5, 12);
    repeat (30) @(negedge clk);
    n_checks++; if (done_pulses - d0 != 1)
      $display("FAIL restart_done_count: got %0d pulses want 1", done_pulses - d0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int s0;
    bit reached;
    core_lat = 10; lat_rand = 1'b0;
    @(negedge clk);
    drive_inputs(16'h0019, 8'hFF, 16'h00C5);
    start = 1'b1;
    s0 = start_pulses;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (start_pulses - s0 >= 2) begin reached = 1'b1; break; end
    end
    n_checks++; if (!reached) $display("FAIL midreset_reach_sq: second launch not seen"); else n_pass++;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL midreset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mont_start !== 1'b0) $display("FAIL midreset_mont_start: got %b want 0", mont_start); else n_pass++;
    n_checks++; if (result !== 16'd0) $display("FAIL midreset_result: got %0h want 0", result); else n_pass++;
    n_checks++; if (mont_a !== 16'd0 || mont_b !== 16'd0) $display("FAIL midreset_operands: got a=%0h b=%0h want 0", mont_a, mont_b); else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    core_lat = 3;
    check_op("after_reset", 16'h0019, 8'h9C, 16'h00C5, -1);
  endtask

  task automatic test_random;
    logic [DW-1:0] m, x;
    logic [EW-1:0] e;
    lat_rand = 1'b1;
    for (int k = 0; k < 15; k++) begin
      m = DW'($urandom_range(3, 65535)) | 16'd1;
      x = DW'($urandom % int'(m));
      e = EW'($urandom_range(0, 255));
      check_op("random", x, e, m, -1);
    end
    lat_rand = 1'b0;
  endtask

  task automatic test_protocol;
    n_checks++; if (stab_err != 0) $display("FAIL operand_stability: %0d changes while busy, want 0", stab_err); else n_pass++;
    n_checks++; if (wide_err != 0) $display("FAIL mont_start_width: %0d multi-cycle pulses, want 0", wide_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
